// File: rtl/mpu_thread_mapman_pkg.sv
// Shared types and default sizing for the MPU thread map manager.
package mpu_thread_mapman_pkg;

  localparam int SIZE_THREAD_MEM_DEF = 1024;
  localparam int NUM_ENTRY_MAP       = SIZE_THREAD_MEM_DEF / 32;
  localparam int WIDTH_TID_DEF       = 8;
  localparam int WIDTH_ADDR_DEF      = $clog2(SIZE_THREAD_MEM_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ACK,
    ST_DROP
  } fsm_mapman_t;

  typedef struct packed {
    logic                      valid;
    logic [WIDTH_TID_DEF-1:0]  tid;
    logic [WIDTH_ADDR_DEF-1:0] base;
    logic [WIDTH_ADDR_DEF:0]   len;
  } mapman_entry_t;

endpackage

// File: rtl/mpu_thread_mapman_ringbuf.sv
// Head/tail pointer pair for the thread map ring; an extra wrap bit separates full from empty.
module mpu_thread_mapman_ringbuf #(
  parameter int NUM_ENTRY = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         I_We,
  input  logic                         I_Re,
  output logic [$clog2(NUM_ENTRY)-1:0] O_Head,
  output logic [$clog2(NUM_ENTRY)-1:0] O_Tail,
  output logic                         O_Full,
  output logic                         O_Empty
);

  localparam int WIDTH_PTR = $clog2(NUM_ENTRY);

  logic [WIDTH_PTR:0] r_head;
  logic [WIDTH_PTR:0] r_tail;
  logic               w_full;
  logic               w_empty;

  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[WIDTH_PTR] != r_tail[WIDTH_PTR]) &&
                   (r_head[WIDTH_PTR-1:0] == r_tail[WIDTH_PTR-1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (I_We && !w_full)  r_head <= r_head + 1'b1;
      if (I_Re && !w_empty) r_tail <= r_tail + 1'b1;
    end
  end

  assign O_Head  = r_head[WIDTH_PTR-1:0];
  assign O_Tail  = r_tail[WIDTH_PTR-1:0];
  assign O_Full  = w_full;
  assign O_Empty = w_empty;

endmodule

// File: rtl/mpu_thread_mapman.sv
// Thread map manager: allocates circular instruction-memory regions per thread-ID, serves lookups, frees in FIFO order.
// ST_IDLE wait req | ST_CHECK dup/space test | ST_ACK commit entry | ST_DROP wait for req low
module mpu_thread_mapman
  import mpu_thread_mapman_pkg::*;
#(
  parameter int SIZE_THREAD_MEM = SIZE_THREAD_MEM_DEF,
  parameter int NUM_ENTRY       = NUM_ENTRY_MAP,
  parameter int WIDTH_TID       = WIDTH_TID_DEF,
  parameter int WIDTH_ADDR      = $clog2(SIZE_THREAD_MEM)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Req_St,
  input  logic [WIDTH_TID-1:0]  I_ThreadID_St,
  input  logic [WIDTH_ADDR:0]   I_Length_St,
  output logic                  O_Ack_St,
  output logic [WIDTH_ADDR-1:0] O_Base_St,
  output logic [WIDTH_ADDR:0]   O_Used_Size,
  output logic                  O_Full,
  output logic                  O_Err_Dup,
  input  logic                  I_Req_Lookup,
  input  logic [WIDTH_TID-1:0]  I_ThreadID_Lookup,
  output logic                  O_Ack_Lookup,
  output logic                  O_Hit,
  output logic [WIDTH_ADDR-1:0] O_Base,
  output logic [WIDTH_ADDR:0]   O_Length,
  input  logic                  I_Release,
  input  logic [WIDTH_TID-1:0]  I_ThreadID_Release,
  output logic                  O_Err_Release
);

  localparam int WIDTH_PTR = $clog2(NUM_ENTRY);
  localparam int WIDTH_SUM = WIDTH_ADDR + 2;
  localparam logic [WIDTH_SUM-1:0] SIZE_SUM = WIDTH_SUM'(SIZE_THREAD_MEM);

  fsm_mapman_t           r_state;
  logic [NUM_ENTRY-1:0]  r_valid;
  logic [WIDTH_TID-1:0]  r_tid  [NUM_ENTRY];
  logic [WIDTH_ADDR-1:0] r_base [NUM_ENTRY];
  logic [WIDTH_ADDR:0]   r_len  [NUM_ENTRY];
  logic [WIDTH_ADDR-1:0] r_next_base;
  logic [WIDTH_ADDR:0]   r_used;
  logic [WIDTH_TID-1:0]  r_tid_req;
  logic [WIDTH_ADDR:0]   r_len_req;

  logic [WIDTH_PTR-1:0]  w_head;
  logic [WIDTH_PTR-1:0]  w_tail;
  logic                  w_ring_full;
  logic                  w_ring_empty;
  logic                  w_we;
  logic                  w_rel_ok;
  logic                  w_dup;
  logic                  w_nospace;
  logic [WIDTH_SUM-1:0]  w_sum;
  logic                  w_lk_hit;
  logic [WIDTH_ADDR-1:0] w_lk_base;
  logic [WIDTH_ADDR:0]   w_lk_len;
  logic [WIDTH_ADDR:0]   w_used_add;
  logic [WIDTH_ADDR:0]   w_used_sub;

  mpu_thread_mapman_ringbuf #(.NUM_ENTRY(NUM_ENTRY)) u_ring (
    .clock   (clock),
    .reset   (reset),
    .I_We    (w_we),
    .I_Re    (w_rel_ok),
    .O_Head  (w_head),
    .O_Tail  (w_tail),
    .O_Full  (w_ring_full),
    .O_Empty (w_ring_empty)
  );

  assign w_we     = (r_state == ST_ACK);
  assign w_rel_ok = I_Release && !w_ring_empty && r_valid[w_tail] &&
                    (r_tid[w_tail] == I_ThreadID_Release);

  // Parallel compare over valid entries for both the store and the lookup ports.
  always_comb begin
    w_dup     = 1'b0;
    w_lk_hit  = 1'b0;
    w_lk_base = '0;
    w_lk_len  = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (r_valid[i] && (r_tid[i] == I_ThreadID_St)) w_dup = 1'b1;
      if (r_valid[i] && (r_tid[i] == I_ThreadID_Lookup)) begin
        w_lk_hit  = 1'b1;
        w_lk_base = r_base[i];
        w_lk_len  = r_len[i];
      end
    end
  end

  assign w_sum     = {1'b0, r_used} + {1'b0, I_Length_St};
  assign w_nospace = w_ring_full || (I_Length_St == '0) ||
                     ({1'b0, I_Length_St} > SIZE_SUM) || (w_sum > SIZE_SUM);

  assign w_used_add = w_we ? r_len_req : '0;
  assign w_used_sub = w_rel_ok ? r_len[w_tail] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      O_Ack_St  <= 1'b0;
      O_Base_St <= '0;
      O_Full    <= 1'b0;
      O_Err_Dup <= 1'b0;
      r_tid_req <= '0;
      r_len_req <= '0;
    end else begin
      O_Ack_St  <= 1'b0;
      O_Full    <= 1'b0;
      O_Err_Dup <= 1'b0;
      case (r_state)
        ST_IDLE: if (I_Req_St) r_state <= ST_CHECK;
        ST_CHECK: begin
          if (!I_Req_St)      r_state   <= ST_IDLE;
          else if (w_dup)     O_Err_Dup <= 1'b1;
          else if (w_nospace) O_Full    <= 1'b1;
          else begin
            r_state   <= ST_ACK;
            O_Ack_St  <= 1'b1;
            O_Base_St <= r_next_base;
            r_tid_req <= I_ThreadID_St;
            r_len_req <= I_Length_St;
          end
        end
        ST_ACK:  r_state <= ST_DROP;
        ST_DROP: if (!I_Req_St) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Allocation commits on leaving ST_ACK, so a same-cycle lookup still sees the old table.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid       <= '0;
      r_next_base   <= '0;
      r_used        <= '0;
      O_Err_Release <= 1'b0;
    end else begin
      if (w_we) begin
        r_valid[w_head] <= 1'b1;
        r_next_base     <= r_next_base + r_len_req[WIDTH_ADDR-1:0];
      end
      if (w_rel_ok) r_valid[w_tail] <= 1'b0;
      r_used <= r_used + w_used_add - w_used_sub;
      if (I_Release && !w_rel_ok) O_Err_Release <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) begin
      r_tid[w_head]  <= r_tid_req;
      r_base[w_head] <= r_next_base;
      r_len[w_head]  <= r_len_req;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      O_Ack_Lookup <= 1'b0;
      O_Hit        <= 1'b0;
      O_Base       <= '0;
      O_Length     <= '0;
    end else begin
      O_Ack_Lookup <= I_Req_Lookup;
      O_Hit        <= I_Req_Lookup && w_lk_hit;
      O_Base       <= I_Req_Lookup ? w_lk_base : '0;
      O_Length     <= I_Req_Lookup ? w_lk_len : '0;
    end
  end

  assign O_Used_Size = r_used;

endmodule
